pll_clken: RTL and testbench



---
 rtl/pll_clken_pkg.sv | 17 +
 rtl/pll_clken_nco.sv | 44 ++++
 rtl/pll_clken.sv | 112 +++++++++++
 tb/tb_pll_clken.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_clken_pkg.sv
// Shared types and sizing helpers for the PLL lock qualifier and clock-enable generator.
package pll_clken_pkg;

    localparam int unsigned UNLOCK_CNT_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    // Qualification counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/pll_clken_nco.sv
// One phase-accumulator channel: carry out of the accumulator becomes a one-cycle enable.
module pll_clken_nco
    import pll_clken_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [ACC_W-1:0] inc_i,
    input  logic             run_i,
    input  logic             en_i,
    output logic             clken_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             clken_q;
    logic             clken_d;
    logic [ACC_W:0]   sum_c;

    // Disabled or not running: accumulator is held at zero and any carry is dropped.
    always_comb begin
        sum_c   = {1'b0, acc_q} + {1'b0, inc_i};
        acc_d   = '0;
        clken_d = 1'b0;
        if (run_i && en_i) begin
            acc_d   = sum_c[ACC_W-1:0];
            clken_d = sum_c[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q   <= '0;
            clken_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            clken_q <= clken_d;
        end
    end

    assign clken_o = clken_q;

endmodule

// File: rtl/pll_clken.sv
// PLL bring-up: synchronizes lock, qualifies it before releasing reset, and drives NCH NCO enables.
module pll_clken
    import pll_clken_pkg::*;
#(
    parameter int unsigned NCH         = 2,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned LOCK_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    pll_lock,
    input  logic [NCH*ACC_W-1:0]    inc,
    input  logic [NCH-1:0]          ch_en,
    output logic                    locked,
    output logic                    rst_out_n,
    output logic [NCH-1:0]          clken,
    output logic [UNLOCK_CNT_W-1:0] unlock_cnt
);

    localparam int unsigned          CNT_W      = cnt_width(LOCK_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [UNLOCK_CNT_W-1:0] UNLOCK_MAX = '1;

    logic [1:0]              sync_q;
    logic                    lock_s;
    state_e                  state_q;
    state_e                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [UNLOCK_CNT_W-1:0] unlock_q;
    logic [UNLOCK_CNT_W-1:0] unlock_d;
    logic                    rst_out_q;
    logic                    rst_out_d;
    logic                    lost_c;
    logic                    run_c;

    assign lock_s = sync_q[1];

    // Next-state, qualification counter and loss-of-lock counting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        unlock_d = unlock_q;
        lost_c   = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    lost_c  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    lost_c  = 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (lost_c && (unlock_q != UNLOCK_MAX)) begin
            unlock_d = unlock_q + UNLOCK_CNT_W'(1);
        end
        rst_out_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= 2'b00;
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            unlock_q  <= '0;
            rst_out_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pll_lock};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            unlock_q  <= unlock_d;
            rst_out_q <= rst_out_d;
        end
    end

    // Channels advance only while RUN persists into the next cycle, so a lock loss drops the carry.
    assign run_c = (state_q == RUN) && lock_s;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pll_clken_nco #(
            .ACC_W (ACC_W)
        ) u_nco (
            .clk     (clk),
            .resetn  (resetn),
            .inc_i   (inc[i*ACC_W +: ACC_W]),
            .run_i   (run_c),
            .en_i    (ch_en[i]),
            .clken_o (clken[i])
        );
    end

    assign locked     = lock_s;
    assign rst_out_n  = rst_out_q;
    assign unlock_cnt = unlock_q;

endmodule

// File: tb/tb_pll_clken.sv
// Directed bench for pll_clken: lock qualification, NCO rates, lock loss, control corner cases, async reset.
module tb_pll_clken;

    localparam int unsigned NCH         = 2;
    localparam int unsigned ACC_W       = 16;
    localparam int unsigned LOCK_CYCLES = 16;

    logic                   clk;
    logic                   resetn;
    logic                   pll_lock;
    logic [NCH*ACC_W-1:0]   inc;
    logic [NCH-1:0]         ch_en;
    logic                   locked;
    logic                   rst_out_n;
    logic [NCH-1:0]         clken;
    logic [7:0]             unlock_cnt;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    pll_clken #(
        .NCH         (NCH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pll_lock   (pll_lock),
        .inc        (inc),
        .ch_en      (ch_en),
        .locked     (locked),
        .rst_out_n  (rst_out_n),
        .clken      (clken),
        .unlock_cnt (unlock_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected ch0 value is queued before the clock edge and retired after it.
    task automatic step_ch0(input string tag, input logic exp);
        logic e;
        exp_q.push_back(exp);
        tick();
        e = exp_q.pop_front();
        check(tag, 32'(clken[0]), 32'(e));
    endtask

    initial begin
        int n0;
        int n1;
        int adj;
        logic prev1;
        bit   seen;

        resetn   = 1'b0;
        pll_lock = 1'b0;
        ch_en    = 2'b11;
        inc      = {16'h5556, 16'h4000};
        #12;
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_rst_out_n", 32'(rst_out_n), 32'd0);
        check("reset_clken", 32'(clken), 32'd0);
        check("reset_unlock_cnt", 32'(unlock_cnt), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check("idle_rst_out_n", 32'(rst_out_n), 32'd0);

        // Lock qualification from a clean pll_lock rise.
        pll_lock = 1'b1;
        tick();
        check("sync_lat_c1", 32'(locked), 32'd0);
        tick();
        check("sync_lat_c2", 32'(locked), 32'd1);
        for (int c = 3; c <= 18; c++) begin
            tick();
            check("qual_rst_low", 32'(rst_out_n), 32'd0);
        end
        check("qual_clken_idle", 32'(clken), 32'd0);

        // Rate check from the first RUN cycle (k=0 at cycle 19).
        n0 = 0;
        n1 = 0;
        adj = 0;
        prev1 = 1'b0;
        for (int k = 0; k <= 3000; k++) begin
            step_ch0("rate_ch0", (k > 0) && (k % 4 == 0));
            if (k == 0) begin
                check("release_rst_out_n", 32'(rst_out_n), 32'd1);
                check("release_unlock_cnt", 32'(unlock_cnt), 32'd0);
            end else begin
                n0 += int'(clken[0]);
                n1 += int'(clken[1]);
                if (prev1 && clken[1]) adj++;
            end
            prev1 = clken[1];
        end
        check("rate_ch0_count", 32'(n0), 32'd750);
        check("rate_ch1_in_range", 32'((n1 >= 999) && (n1 <= 1001)), 32'd1);
        check("rate_ch1_no_adjacent", 32'(adj), 32'd0);

        // Lock loss in RUN with ch0 mid-period; its pending carry must be dropped.
        step_ch0("loss_k3001", 1'b0);
        pll_lock = 1'b0;
        tick();
        tick();
        check("loss_locked_low", 32'(locked), 32'd0);
        check("loss_rst_still_high", 32'(rst_out_n), 32'd1);
        step_ch0("loss_carry_dropped", 1'b0);
        check("loss_rst_low", 32'(rst_out_n), 32'd0);
        check("loss_unlock_cnt", 32'(unlock_cnt), 32'd1);

        // Re-lock: reset release after LOCK_CYCLES+3 and ch0 restarts from zero phase.
        pll_lock = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            check("relock_rst_low", 32'(rst_out_n), 32'd0);
        end
        for (int k = 0; k <= 6; k++) begin
            step_ch0("relock_ch0", (k == 4));
        end
        check("relock_rst_high", 32'(rst_out_n), 32'd1);

        // ch_en[0] dropped on the carry cycle: no pulse and accumulator cleared.
        step_ch0("en_k7", 1'b0);
        ch_en[0] = 1'b0;
        step_ch0("en_drop_carry", 1'b0);
        ch_en[0] = 1'b1;
        for (int k = 9; k <= 12; k++) begin
            step_ch0("en_restart", (k == 12));
        end

        // Lock glitch during STABLE restarts qualification.
        pll_lock = 1'b0;
        tick();
        tick();
        tick();
        check("drop_unlock_cnt", 32'(unlock_cnt), 32'd2);
        pll_lock = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            check("glitch_rst_low", 32'(rst_out_n), 32'd0);
        end
        check("glitch_unlock_cnt", 32'(unlock_cnt), 32'd3);
        tick();
        check("glitch_rst_release", 32'(rst_out_n), 32'd1);

        // inc=0 yields no pulses.
        inc[15:0] = 16'h0000;
        n0 = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            n0 += int'(clken[0]);
        end
        check("inc_zero_no_pulse", 32'(n0), 32'd0);

        // 300 lock losses saturate the counter.
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            tick();
            tick();
            tick();
            pll_lock = 1'b1;
            for (int c = 0; c < 4; c++) tick();
        end
        check("unlock_saturate", 32'(unlock_cnt), 32'd255);

        // Async reset between edges while a pulse is visible.
        inc[15:0] = 16'h8000;
        for (int c = 0; c < 25; c++) tick();
        check("pre_async_rst_high", 32'(rst_out_n), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            tick();
            if (clken[0]) seen = 1'b1;
        end
        check("pre_async_pulse_seen", 32'(seen), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_locked", 32'(locked), 32'd0);
        check("async_rst_out_n", 32'(rst_out_n), 32'd0);
        check("async_clken", 32'(clken), 32'd0);
        check("async_unlock_cnt", 32'(unlock_cnt), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
